// File: rtl/tri_sample_iter.sv
// Bounding-box sample iterator: walks a triangle's box in raster order at the
// selected sub-sample step, presenting one candidate sample per cycle.
module tri_sample_iter #(
  parameter int SIGFIG = 24,
  parameter int RADIX  = 10,
  parameter int VERTS  = 3,
  parameter int AXIS   = 3,
  parameter int COLORS = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [SIGFIG-1:0] tri_R13S   [VERTS][AXIS],
  input  logic        [SIGFIG-1:0] color_R13U [COLORS],
  input  logic signed [SIGFIG-1:0] box_R13S   [2][2],
  input  logic                     validTri_R13H,
  input  logic        [3:0]        subSample_RnnnnU,
  output logic                     halt_RnnnnH,
  output logic signed [SIGFIG-1:0] tri_R14S   [VERTS][AXIS],
  output logic        [SIGFIG-1:0] color_R14U [COLORS],
  output logic signed [SIGFIG-1:0] sample_R14S [2],
  output logic                     validSamp_R14H
);

  // Handshake: upstream offers a triangle with validTri_R13H and must hold it
  // while halt_RnnnnH=1; a triangle is taken on any edge where the FSM is in
  // WAIT and validTri_R13H=1, and validTri_R13H is ignored otherwise.
  typedef enum logic {S_WAIT, S_TEST} state_t;

  state_t                   state_q;
  logic signed [SIGFIG-1:0] tri_q    [VERTS][AXIS];
  logic        [SIGFIG-1:0] color_q  [COLORS];
  logic signed [SIGFIG-1:0] box_q    [2][2];
  logic signed [SIGFIG-1:0] sample_q [2];
  logic signed [SIGFIG-1:0] step_q;
  logic                     valid_q;
  logic                     halt_q;

  logic signed [SIGFIG-1:0] step_d;
  logic signed [SIGFIG:0]   x_ext_d, y_ext_d, step_ext_d, urx_ext_d, ury_ext_d;
  logic signed [SIGFIG:0]   nx_d, ny_d;
  logic                     x_over_d, y_over_d;

  localparam logic signed [SIGFIG-1:0] ONE = {{(SIGFIG-1){1'b0}}, 1'b1};

  always_comb begin
    step_d = ONE << RADIX;
    case (subSample_RnnnnU)
      4'b0100: step_d = ONE << (RADIX - 1);
      4'b0010: step_d = ONE << (RADIX - 2);
      4'b0001: step_d = ONE << (RADIX - 3);
      default: step_d = ONE << RADIX;
    endcase
  end

  // One extra bit keeps x+step from wrapping negative near the positive limit.
  assign x_ext_d    = {sample_q[0][SIGFIG-1], sample_q[0]};
  assign y_ext_d    = {sample_q[1][SIGFIG-1], sample_q[1]};
  assign step_ext_d = {step_q[SIGFIG-1], step_q};
  assign urx_ext_d  = {box_q[1][0][SIGFIG-1], box_q[1][0]};
  assign ury_ext_d  = {box_q[1][1][SIGFIG-1], box_q[1][1]};
  assign nx_d       = x_ext_d + step_ext_d;
  assign ny_d       = y_ext_d + step_ext_d;
  assign x_over_d   = nx_d > urx_ext_d;
  assign y_over_d   = ny_d > ury_ext_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_WAIT;
      valid_q <= 1'b0;
      halt_q  <= 1'b0;
      step_q  <= '0;
      for (int v = 0; v < VERTS; v++)
        for (int a = 0; a < AXIS; a++) tri_q[v][a] <= '0;
      for (int c = 0; c < COLORS; c++) color_q[c] <= '0;
      for (int i = 0; i < 2; i++) begin
        sample_q[i] <= '0;
        box_q[i][0] <= '0;
        box_q[i][1] <= '0;
      end
    end else begin
      case (state_q)
        S_WAIT: begin
          valid_q <= 1'b0;
          halt_q  <= 1'b0;
          if (validTri_R13H) begin
            tri_q       <= tri_R13S;
            color_q     <= color_R13U;
            box_q       <= box_R13S;
            step_q      <= step_d;
            sample_q[0] <= box_R13S[0][0];
            sample_q[1] <= box_R13S[0][1];
            valid_q     <= 1'b1;
            halt_q      <= 1'b1;
            state_q     <= S_TEST;
          end
        end
        S_TEST: begin
          if (x_over_d && y_over_d) begin
            valid_q <= 1'b0;
            halt_q  <= 1'b0;
            state_q <= S_WAIT;
          end else if (x_over_d) begin
            sample_q[0] <= box_q[0][0];
            sample_q[1] <= ny_d[SIGFIG-1:0];
          end else begin
            sample_q[0] <= nx_d[SIGFIG-1:0];
          end
        end
        default: state_q <= S_WAIT;
      endcase
    end
  end

  assign halt_RnnnnH    = halt_q;
  assign validSamp_R14H = valid_q;
  assign tri_R14S       = tri_q;
  assign color_R14U     = color_q;
  assign sample_R14S    = sample_q;

  // An inverted box has no defined iteration; flag it when it is taken.
  a_box_ordered: assert property (@(posedge clk) disable iff (rst)
    (state_q == S_WAIT && validTri_R13H) |->
      (box_R13S[1][0] >= box_R13S[0][0] && box_R13S[1][1] >= box_R13S[0][1]));

endmodule
